uart_rx_word: RTL

- Upstream stage of the UART loopback debug path.
- Deserialises the asynchronous `uart_rx` line into bytes and packs 4 consecutive bytes, little-endian, into a 32-bit `rx_data` word.
- Pulses `Rx_Done` once per completed word.
- `rx_data` and `Rx_Done` feed the loopback transmitter and are the probed signals of the on-chip logic analyzer, so both must be glitch-free registered outputs on `Clk`.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_byte.sv | 131 +++++++++++++
 rtl/uart_rx_word.sv | 114 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART word receiver: bit-FSM states, data width,
// and baud-divider arithmetic.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  function automatic int calc_bit_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // Counter must hold BIT_DIV-1.
  function automatic int calc_cnt_w(input int bit_div);
    return (bit_div > 2) ? $clog2(bit_div) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Byte-level UART receiver: 2-flop synchroniser, mid-bit baud counter and bit FSM.
// Optional even-parity bit when UART_RX_PARITY_EN is defined.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic                 byte_valid,
  output logic [DATA_BITS-1:0] byte_data,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 idle,
  output logic                 start_edge
);

  localparam int BIT_DIV = calc_bit_div(CLK_FREQ, BAUD);
  localparam int CW      = calc_cnt_w(BIT_DIV);
  localparam logic [CW-1:0] HALF_LD = CW'(BIT_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LD = CW'(BIT_DIV - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  rx_state_t state, state_nxt;
  logic rx_m, rx_s, rx_d;
  logic [1:0] fill;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic tick, fall;
`ifdef UART_RX_PARITY_EN
  logic par_bad;
`endif

  // fill keeps the preset synchroniser values from looking like a start edge
  // after reset; a genuine high-to-low transition of the line is required.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
      fill <= 2'd0;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
      if (fill != 2'd3) fill <= fill + 2'd1;
    end
  end

  assign fall       = (fill == 2'd3) && rx_d && !rx_s;
  assign tick       = (cnt == '0);
  assign idle       = (state == IDLE);
  assign start_edge = idle && fall;
  assign byte_data  = shreg;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (fall) state_nxt = START;
      START: if (tick) state_nxt = rx_s ? IDLE : DATA;
      DATA:
        if (tick && bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      PARITY: if (tick) state_nxt = STOP;
      STOP:   if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      bit_idx    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (state == IDLE) begin
        bit_idx <= '0;
        if (fall) cnt <= HALF_LD;
      end else begin
        cnt <= tick ? FULL_LD : cnt - 1'b1;
      end
      if (tick) begin
        case (state)
          DATA: begin
            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 3'd1;
          end
`ifdef UART_RX_PARITY_EN
          PARITY: par_bad <= (rx_s != ^shreg);
          STOP: begin
            byte_valid <= rx_s && !par_bad;
            frame_err  <= !rx_s;
            parity_err <= rx_s && par_bad;
          end
`else
          STOP: begin
            byte_valid <= rx_s;
            frame_err  <= !rx_s;
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/uart_rx_word.sv
// UART word receiver: packs BYTES_PER_WORD bytes little-endian into rx_data, drops
// partial words on idle timeout. UART_RX_PARITY_EN adds even parity and rx_parity_err.
module uart_rx_word
  import uart_pkg::*;
#(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int BAUD           = 115200,
  parameter int BYTES_PER_WORD = 4,
  parameter int TIMEOUT_BITS   = 32
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        uart_rx,
  output logic [8*BYTES_PER_WORD-1:0] rx_data,
  output logic                        Rx_Done,
  output logic                        rx_frame_err,
  output logic                        rx_timeout,
`ifdef UART_RX_PARITY_EN
  output logic                        rx_parity_err,
`endif
  output logic                        rx_busy
);

  localparam int BIT_DIV  = calc_bit_div(CLK_FREQ, BAUD);
  localparam int IDX_W    = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int TO_LIMIT = TIMEOUT_BITS * BIT_DIV;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_LIMIT - 1);

  logic byte_valid, frame_err, idle, start_edge, drop;
  logic [DATA_BITS-1:0] byte_data;
  logic [BYTES_PER_WORD-1:0][7:0] stage, word_nxt;
  logic [IDX_W-1:0] idx;
  logic [TO_W-1:0] tcnt;
  logic to_fire;
`ifdef UART_RX_PARITY_EN
  logic parity_err;
`endif

  uart_rx_byte #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) u_byte (
    .clk       (Clk),
    .rst       (Reset),
    .rx        (uart_rx),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .idle      (idle),
    .start_edge(start_edge)
  );

`ifdef UART_RX_PARITY_EN
  assign drop = frame_err || parity_err;
`else
  assign drop = frame_err;
`endif

  assign rx_busy = !idle;

  // A start edge wins over an expiring timeout in the same cycle.
  assign to_fire = !start_edge && !byte_valid && (idx != '0) && idle && (tcnt == TO_LAST);

  always_comb begin
    word_nxt = stage;
    word_nxt[BYTES_PER_WORD-1] = byte_data;
  end

  always_ff @(posedge Clk) begin
    if (to_fire) stage <= '0;
    else if (byte_valid && idx != LAST_IDX) stage[idx] <= byte_data;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rx_data      <= '0;
      Rx_Done      <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_timeout   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      rx_parity_err <= 1'b0;
`endif
      idx          <= '0;
      tcnt         <= '0;
    end else begin
      Rx_Done      <= 1'b0;
      rx_frame_err <= frame_err;
      rx_timeout   <= to_fire;
`ifdef UART_RX_PARITY_EN
      rx_parity_err <= parity_err;
`endif
      if (byte_valid) begin
        if (idx == LAST_IDX) begin
          rx_data <= word_nxt;
          Rx_Done <= 1'b1;
          idx     <= '0;
        end else begin
          idx <= idx + 1'b1;
        end
      end else if (drop || to_fire) begin
        idx <= '0;
      end
      // Idle time is measured from the last accepted byte of a partial word.
      if (start_edge || byte_valid || idx == '0 || to_fire) tcnt <= '0;
      else if (idle) tcnt <= tcnt + 1'b1;
    end
  end

endmodule
